seg14_scan_decoder: RTL and testbench

//  Receive side of the multiplexed 14-segment display bus (one-hot sel[11:0] + segm[13:0]).

---
 rtl/seg14_pkg.sv | 72 +++++++
 rtl/seg14_glyph_lut.sv | 32 +++
 rtl/seg14_scan_decoder.sv | 156 +++++++++++++++
 tb/tb_seg14_scan_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg14_pkg.sv
//==============================================================================
// seg14_pkg : constants, glyph patterns and FSM state type for the 14-segment bus
// Revision  : 1.0
//==============================================================================
`default_nettype none

package seg14_pkg;

  localparam int NPOS = 12;
  localparam int NSEG = 14;
  localparam int CW   = 6;

  typedef enum logic [0:0] {
    SYNC    = 1'b0,
    CAPTURE = 1'b1
  } state_e;

  localparam logic [CW-1:0] CODE_SPACE   = 6'd0;
  localparam logic [CW-1:0] CODE_A       = 6'd1;
  localparam logic [CW-1:0] CODE_NTILDE  = 6'd27;
  localparam logic [CW-1:0] CODE_DIGIT0  = 6'd28;
  localparam logic [CW-1:0] CODE_UNKNOWN = 6'd63;

  // Bit order [13:0] = a b c d e f g1 g2 h i j k l m (h..m are the diagonals/centre bars)
  localparam logic [NSEG-1:0] PAT_SPACE  = 14'b00000000000000;
  localparam logic [NSEG-1:0] PAT_NTILDE = 14'b11101100100001;

  localparam logic [NSEG-1:0] PAT_LETTER [26] = '{
    14'b11101111000000,  // A
    14'b11110001010010,  // B
    14'b10011100000000,  // C
    14'b11110000010010,  // D
    14'b10011110000000,  // E
    14'b10001110000000,  // F
    14'b10111101000000,  // G
    14'b01101111000000,  // H
    14'b10010000010010,  // I
    14'b01111000000000,  // J
    14'b00001110001001,  // K
    14'b00011100000000,  // L
    14'b01101100101000,  // M
    14'b01101100100001,  // N
    14'b11111100000000,  // O
    14'b11001111000000,  // P
    14'b11111100000001,  // Q
    14'b11001111000001,  // R
    14'b10110111000000,  // S
    14'b10000000010010,  // T
    14'b01111100000000,  // U
    14'b00001100001100,  // V
    14'b01101100000101,  // W
    14'b00000000101101,  // X
    14'b00000000101010,  // Y
    14'b10010000001100   // Z
  };

  localparam logic [NSEG-1:0] PAT_DIGIT [10] = '{
    14'b11111100001100,  // 0
    14'b01100000001000,  // 1
    14'b11011011000000,  // 2
    14'b11110001000000,  // 3
    14'b01100111000000,  // 4
    14'b10110111000000,  // 5 (same glyph as S)
    14'b10111111000000,  // 6
    14'b11100000000000,  // 7
    14'b11111111000000,  // 8
    14'b11110111000000   // 9
  };

endpackage

`default_nettype wire

// File: rtl/seg14_glyph_lut.sv
//==============================================================================
// seg14_glyph_lut : segment pattern -> character code (combinational)
// Optional SEG14_DIGIT_DECODE_EN adds digits 0..9 as codes 28..37.  Revision 1.0
//==============================================================================
`default_nettype none

module seg14_glyph_lut
  import seg14_pkg::*;
(
  input  logic [NSEG-1:0] segm_i,
  output logic [CW-1:0]   code_o
);

  // Digits are matched before letters so a shared glyph (5 / S) resolves to the letter.
  always_comb begin
    code_o = CODE_UNKNOWN;
    if (segm_i == PAT_SPACE) code_o = CODE_SPACE;
`ifdef SEG14_DIGIT_DECODE_EN
    for (int i = 0; i < 10; i++) begin
      if (segm_i == PAT_DIGIT[i]) code_o = CODE_DIGIT0 + 6'(i);
    end
`else
`endif
    for (int i = 0; i < 26; i++) begin
      if (segm_i == PAT_LETTER[i]) code_o = CODE_A + 6'(i);
    end
    if (segm_i == PAT_NTILDE) code_o = CODE_NTILDE;
  end

endmodule

`default_nettype wire

// File: rtl/seg14_scan_decoder.sv
//==============================================================================
// seg14_scan_decoder : rebuilds 12-character frames from the multiplexed 14-seg scan
// Build option SEG14_DIGIT_DECODE_EN (digit decode, in seg14_glyph_lut).  Revision 1.0
//==============================================================================
`default_nettype none

module seg14_scan_decoder
  import seg14_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NPOS-1:0] sel_i,
  input  logic [NSEG-1:0] segm_i,
  input  logic [3:0]      rd_addr_i,
  output logic [CW-1:0]   rd_char_o,
  output logic            frame_valid_o,
  output logic            frame_changed_o,
  output logic [7:0]      frame_count_o,
  output logic            err_sel_o,
  output logic            err_seq_o,
  output logic            unknown_seen_o
);

  logic [NPOS-1:0]          sel_q;
  logic [NSEG-1:0]          segm_q;
  logic                     smp_vld_q;
  state_e                   state_q, state_d;
  logic [3:0]               expect_q, expect_d;
  logic [NPOS-1:0][CW-1:0]  cap_q, cap_d, pub_q, pub_d, new_frame;
  logic                     fv_q, fv_d, fc_q, fc_d, es_q, es_d, eq_q, eq_d, unk_q, unk_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [CW-1:0]            code;
  logic [3:0]               pos;
  logic                     onehot, wr_en, complete, has_unknown;

  seg14_glyph_lut u_lut (
    .segm_i (segm_q),
    .code_o (code)
  );

  assign onehot = $onehot(sel_q);

  always_comb begin
    pos = '0;
    for (int i = 0; i < NPOS; i++) begin
      if (sel_q[i]) pos = 4'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    expect_d  = expect_q;
    fv_d      = 1'b0;
    fc_d      = 1'b0;
    es_d      = 1'b0;
    eq_d      = 1'b0;
    unk_d     = unk_q;
    cnt_d     = cnt_q;
    pub_d     = pub_q;
    wr_en     = 1'b0;
    complete  = 1'b0;
    new_frame = cap_q;
    has_unknown = 1'b0;

    // smp_vld_q masks the reset value of the input stage on the first edge after reset
    if (smp_vld_q) begin
      if (!onehot) begin
        es_d    = 1'b1;
        state_d = SYNC;
      end else if (state_q == SYNC) begin
        if (pos == 4'd0) begin
          wr_en    = 1'b1;
          expect_d = 4'd1;
          state_d  = CAPTURE;
        end
      end else if (pos == expect_q) begin
        wr_en    = 1'b1;
        expect_d = expect_q + 4'd1;
        complete = (pos == 4'(NPOS - 1));
      end else if (pos == expect_q - 4'd1) begin
        wr_en = 1'b1;
      end else if (pos == 4'd0) begin
        eq_d     = 1'b1;
        wr_en    = 1'b1;
        expect_d = 4'd1;
      end else begin
        eq_d    = 1'b1;
        state_d = SYNC;
      end
    end

    if (wr_en) new_frame[pos] = code;
    cap_d = new_frame;

    for (int i = 0; i < NPOS; i++) begin
      if (new_frame[i] == CODE_UNKNOWN) has_unknown = 1'b1;
    end

    if (complete) begin
      pub_d    = new_frame;
      fv_d     = 1'b1;
      fc_d     = (new_frame != pub_q);
      cnt_d    = cnt_q + 8'd1;
      unk_d    = has_unknown;
      state_d  = SYNC;
      expect_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= '0;
      segm_q    <= '0;
      smp_vld_q <= 1'b0;
      state_q   <= SYNC;
      expect_q  <= '0;
      cap_q     <= '0;
      pub_q     <= '0;
      fv_q      <= 1'b0;
      fc_q      <= 1'b0;
      es_q      <= 1'b0;
      eq_q      <= 1'b0;
      unk_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sel_q     <= sel_i;
      segm_q    <= segm_i;
      smp_vld_q <= 1'b1;
      state_q   <= state_d;
      expect_q  <= expect_d;
      cap_q     <= cap_d;
      pub_q     <= pub_d;
      fv_q      <= fv_d;
      fc_q      <= fc_d;
      es_q      <= es_d;
      eq_q      <= eq_d;
      unk_q     <= unk_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    rd_char_o = '0;
    if (rd_addr_i < 4'(NPOS)) rd_char_o = pub_q[rd_addr_i];
  end

  assign frame_valid_o   = fv_q;
  assign frame_changed_o = fc_q;
  assign frame_count_o   = cnt_q;
  assign err_sel_o       = es_q;
  assign err_seq_o       = eq_q;
  assign unknown_seen_o  = unk_q;

endmodule

`default_nettype wire

// File: tb/tb_seg14_scan_decoder.sv
// Directed bench for seg14_scan_decoder; glyph patterns and expected codes are written out by hand.
`default_nettype none

module tb_seg14_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sel_i;
  logic [13:0] segm_i;
  logic [3:0]  rd_addr_i;
  logic [5:0]  rd_char_o;
  logic        frame_valid_o, frame_changed_o, err_sel_o, err_seq_o, unknown_seen_o;
  logic [7:0]  frame_count_o;

  int total = 0;
  int fails = 0;
  int fv_cnt = 0;
  logic [7:0] chg_log = '0;

  localparam logic [13:0] P_A = 14'b11101111000000;
  localparam logic [13:0] P_B = 14'b11110001010010;
  localparam logic [13:0] P_C = 14'b10011100000000;
  localparam logic [13:0] P_D = 14'b11110000010010;
  localparam logic [13:0] P_E = 14'b10011110000000;
  localparam logic [13:0] P_F = 14'b10001110000000;
  localparam logic [13:0] P_G = 14'b10111101000000;
  localparam logic [13:0] P_H = 14'b01101111000000;
  localparam logic [13:0] P_I = 14'b10010000010010;
  localparam logic [13:0] P_J = 14'b01111000000000;
  localparam logic [13:0] P_K = 14'b00001110001001;
  localparam logic [13:0] P_L = 14'b00011100000000;
  localparam logic [13:0] P_M = 14'b01101100101000;
  localparam logic [13:0] P_S = 14'b10110111000000;
  localparam logic [13:0] P_9 = 14'b11110111000000;

`ifdef SEG14_DIGIT_DECODE_EN
  localparam logic [5:0] EXP_NINE = 6'd37;
  localparam logic       EXP_UNK  = 1'b0;
`else
  localparam logic [5:0] EXP_NINE = 6'd63;
  localparam logic       EXP_UNK  = 1'b1;
`endif

  logic [11:0][13:0] fr_al, fr_m, fr_tmp;

  seg14_scan_decoder dut (
    .clk             (clk),
    .rst             (rst),
    .sel_i           (sel_i),
    .segm_i          (segm_i),
    .rd_addr_i       (rd_addr_i),
    .rd_char_o       (rd_char_o),
    .frame_valid_o   (frame_valid_o),
    .frame_changed_o (frame_changed_o),
    .frame_count_o   (frame_count_o),
    .err_sel_o       (err_sel_o),
    .err_seq_o       (err_seq_o),
    .unknown_seen_o  (unknown_seen_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid_o === 1'b1) begin
      fv_cnt++;
      chg_log = {chg_log[6:0], frame_changed_o};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [11:0] s, input logic [13:0] p);
    @(negedge clk);
    sel_i  = s;
    segm_i = p;
  endtask

  task automatic drive_frame(input logic [11:0][13:0] p);
    for (int i = 0; i < 12; i++) drive(12'(1 << i), p[i]);
  endtask

  // One idle slot, then land on the negedge just after the publishing edge.
  task automatic to_publish();
    drive(12'h800, 14'h0);
    @(negedge clk);
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] a, input logic [5:0] exp);
    rd_addr_i = a;
    #1;
    chk(tag, 32'(rd_char_o), 32'(exp));
  endtask

  initial begin
    fr_al = {P_L, P_K, P_J, P_I, P_H, P_G, P_F, P_E, P_D, P_C, P_B, P_A};
    fr_m  = fr_al;
    fr_m[4] = P_M;
    rst = 1'b1;
    sel_i = 12'h800;
    segm_i = '0;
    rd_addr_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_fv", 32'(frame_valid_o), 0);
    chk("rst_cnt", 32'(frame_count_o), 0);
    chk("rst_errs", 32'({err_sel_o, err_seq_o, unknown_seen_o, frame_changed_o}), 0);
    chk_rd("rst_rd0", 4'd0, 6'd0);
    rst = 1'b0;

    // 1: in-order frame A..L
    drive_frame(fr_al);
    drive(12'h800, 14'h0);
    chk("t1_pre_fv", 32'(frame_valid_o), 0);
    @(negedge clk);
    chk("t1_fv", 32'(frame_valid_o), 1);
    chk("t1_chg", 32'(frame_changed_o), 1);
    chk("t1_cnt", 32'(frame_count_o), 1);
    chk("t1_errs", 32'({err_sel_o, err_seq_o, unknown_seen_o}), 0);
    for (int i = 0; i < 12; i++) chk_rd("t1_rd", 4'(i), 6'(i + 1));
    chk_rd("t1_rd12", 4'd12, 6'd0);
    chk_rd("t1_rd15", 4'd15, 6'd0);
    chk("t1_fv_drop", 32'(frame_valid_o), 0);

    // 2: identical frame, then back-to-back identical + slot4=M
    drive_frame(fr_al);
    to_publish();
    chk("t2_fv", 32'(frame_valid_o), 1);
    chk("t2_chg", 32'(frame_changed_o), 0);
    chk("t2_cnt", 32'(frame_count_o), 2);
    drive_frame(fr_al);
    drive_frame(fr_m);
    to_publish();
    #1;
    chk("t2b_fv", 32'(frame_valid_o), 1);
    chk("t2b_chg", 32'(frame_changed_o), 1);
    chk("t2b_cnt", 32'(frame_count_o), 4);
    chk("t2b_pulses", 32'(fv_cnt), 4);
    chk("t2b_first_chg", 32'(chg_log[1]), 0);
    chk_rd("t2b_rd4", 4'd4, 6'd13);
    chk_rd("t2b_rd0", 4'd0, 6'd1);

    // 3: zero then multi-hot select mid-frame
    for (int i = 0; i < 5; i++) drive(12'(1 << i), fr_al[i]);
    drive(12'h000, P_F);
    drive(12'h003, P_A);
    drive(12'h800, 14'h0);
    chk("t3_esel1", 32'(err_sel_o), 1);
    chk("t3_eseq1", 32'(err_seq_o), 0);
    @(negedge clk);
    chk("t3_esel2", 32'(err_sel_o), 1);
    @(negedge clk);
    chk("t3_esel_drop", 32'(err_sel_o), 0);
    chk("t3_nofv_cnt", 32'(frame_count_o), 4);
    drive_frame(fr_al);
    to_publish();
    chk("t3_fv", 32'(frame_valid_o), 1);
    chk("t3_cnt", 32'(frame_count_o), 5);
    chk("t3_chg", 32'(frame_changed_o), 1);

    // 4: skip to slot 5 (err_seq, SYNC), then 0,1,2,0 restart
    drive(12'h001, P_A);
    drive(12'h002, P_B);
    drive(12'h004, P_C);
    drive(12'h020, P_F);
    drive(12'h040, P_G);
    drive(12'h800, 14'h0);
    chk("t4_eseq", 32'(err_seq_o), 1);
    chk("t4_esel", 32'(err_sel_o), 0);
    @(negedge clk);
    chk("t4_sync_ignore", 32'(err_seq_o), 0);
    drive(12'h001, P_A);
    drive(12'h002, P_B);
    drive(12'h004, P_C);
    drive(12'h001, P_M);
    drive(12'h002, P_B);
    drive(12'h004, P_C);
    chk("t4_restart_eseq", 32'(err_seq_o), 1);
    for (int i = 3; i < 12; i++) drive(12'(1 << i), fr_al[i]);
    to_publish();
    chk("t4_fv", 32'(frame_valid_o), 1);
    chk("t4_cnt", 32'(frame_count_o), 6);
    chk_rd("t4_rd0", 4'd0, 6'd13);
    chk_rd("t4_rd1", 4'd1, 6'd2);
    chk_rd("t4_rd11", 4'd11, 6'd12);

    // 5: digit 9 glyph, then S glyph at slot 7
    fr_tmp = fr_al;
    fr_tmp[7] = P_9;
    drive_frame(fr_tmp);
    to_publish();
    chk("t5_cnt9", 32'(frame_count_o), 7);
    chk("t5_unk9", 32'(unknown_seen_o), 32'(EXP_UNK));
    chk_rd("t5_rd7_nine", 4'd7, EXP_NINE);
    fr_tmp[7] = P_S;
    drive_frame(fr_tmp);
    to_publish();
    chk("t5_cntS", 32'(frame_count_o), 8);
    chk("t5_unkS", 32'(unknown_seen_o), 0);
    chk_rd("t5_rd7_S", 4'd7, 6'd19);

    // 6: reset in the middle of a frame
    for (int i = 0; i < 6; i++) drive(12'(1 << i), fr_al[i]);
    @(negedge clk);
    rst = 1'b1;
    sel_i = 12'h040;
    segm_i = P_G;
    @(negedge clk);
    chk("t6_fv", 32'(frame_valid_o), 0);
    chk("t6_cnt", 32'(frame_count_o), 0);
    chk("t6_flags", 32'({err_sel_o, err_seq_o, unknown_seen_o, frame_changed_o}), 0);
    chk_rd("t6_rd0", 4'd0, 6'd0);
    chk_rd("t6_rd7", 4'd7, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    sel_i = 12'h800;
    drive_frame(fr_al);
    to_publish();
    chk("t6_post_fv", 32'(frame_valid_o), 1);
    chk("t6_post_cnt", 32'(frame_count_o), 1);
    chk("t6_post_chg", 32'(frame_changed_o), 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

`default_nettype wire
